// File: rtl/clefia_pkg.sv
// Shared definitions for the CLEFIA diffusion datapath.
//   - GF(2^8) reduction constant and xtime helper for x^8+x^4+x^3+x^2+1
//   - matrix select encoding (one bit per lane)
//   - word_t: one 32-bit word viewed as four bytes, X0 in [3] (bits 31:24)
//   - state_e: serial-mode FSM states (also visible on dbg_state)
package clefia_pkg;

  localparam logic [7:0] GF_POLY_LOW = 8'h1D;

  localparam logic SEL_M0 = 1'b0;
  localparam logic SEL_M1 = 1'b1;

  typedef logic [3:0][7:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Multiply by x; fold the carried-out x^8 term back in as 0x1D.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY_LOW : 8'h00);
  endfunction

endpackage

// File: rtl/clefia_m0m1_core.sv
// Combinational CLEFIA diffusion of one 32-bit word by M0 or M1.
// Ports:
//   word_i : X0=[31:24] .. X3=[7:0]
//   sel_i  : SEL_M0 / SEL_M1
//   word_o : Y0=[31:24] .. Y3=[7:0]
// Both matrices have the form coef[r ^ c], so each output byte is
// X_r ^ k1*X_(r^1) ^ k2*X_(r^2) ^ k3*X_(r^3) with
//   M0: k1=2, k2=4, k3=6      M1: k1=8, k2=2, k3=A
module clefia_m0m1_core
  import clefia_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic        sel_i,
  output logic [31:0] word_o
);

  word_t x;
  word_t m2, m4, m8;
  word_t y;

  assign x = word_i;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      m2[b] = gf_xtime(x[b]);
      m4[b] = gf_xtime(m2[b]);
      m8[b] = gf_xtime(m4[b]);
    end
  end

  // Byte b of the packed word holds X_(3-b); r^1, r^2, r^3 map the same
  // way on the packed index, so the permutation can be applied directly.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      if (sel_i == SEL_M1) begin
        y[b] = x[b] ^ m8[b ^ 1] ^ m2[b ^ 2] ^ m8[b ^ 3] ^ m2[b ^ 3];
      end else begin
        y[b] = x[b] ^ m2[b ^ 1] ^ m4[b ^ 2] ^ m4[b ^ 3] ^ m2[b ^ 3];
      end
    end
  end

  assign word_o = y;

endmodule

// File: rtl/clefia_diffusion_pipe.sv
// Streaming CLEFIA diffusion: applies M0/M1 (chosen per lane) to LANES
// 32-bit words per transaction.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake, in_data lane i at [32i+31:32i]
//   in_sel               : bit i selects M1 (1) or M0 (0) for lane i
//   out_valid/out_ready  : output handshake, out_data same lane layout
//   dbg_state            : serial FSM state (ST_IDLE when SERIAL=0)
// Handshake: a beat transfers on a rising edge where valid & ready are
// both high; a producer holding valid may still change its payload
// until it is accepted, and a stalled output holds data and valid.
// SERIAL=0: PIPE (1 or 2) register stages, matrix before the last one.
// SERIAL=1: one shared core walks the lanes of a captured buffer.
module clefia_diffusion_pipe
  import clefia_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int SERIAL = 0,
  parameter int PIPE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_data,
  input  logic [LANES-1:0]      in_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_data,
  output logic [1:0]            dbg_state
);

  if (SERIAL != 0) begin : g_serial
    // Counter and buffers sized to a power of two so the lane index
    // always spans the array exactly; slots above LANES stay zero.
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int NB = 1 << CW;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NB-1:0][31:0] buf_q, buf_d;
    logic [NB-1:0]       bsel_q, bsel_d;
    logic [31:0]         core_res;

    clefia_m0m1_core u_core (
      .word_i (buf_q[cnt_q]),
      .sel_i  (bsel_q[cnt_q]),
      .word_o (core_res)
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        buf_q   <= '0;
        bsel_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        buf_q   <= buf_d;
        bsel_q  <= bsel_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      buf_d     = buf_q;
      bsel_d    = bsel_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          in_ready = 1'b1;
          if (in_valid) state_d = ST_RUN;
        end
        ST_RUN: begin
          buf_d[cnt_q] = core_res;
          if (cnt_q == CW'(LANES - 1)) state_d = ST_DONE;
          else                         cnt_d   = cnt_q + 1'b1;
        end
        ST_DONE: begin
          out_valid = 1'b1;
          // Result leaving this cycle frees the buffer for a new capture.
          in_ready  = out_ready;
          if (out_ready) state_d = in_valid ? ST_RUN : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (in_valid && in_ready) begin
        buf_d              = '0;
        buf_d[LANES-1:0]   = in_data;
        bsel_d             = '0;
        bsel_d[LANES-1:0]  = in_sel;
        cnt_d              = '0;
      end
    end

    assign out_data  = buf_q[LANES-1:0];
    assign dbg_state = state_q;

  end else begin : g_par
    logic                  mix_vld;
    logic [32*LANES-1:0]   mix_src, mix_res;
    logic [LANES-1:0]      mix_sel;
    logic                  out_vld_q;
    logic [32*LANES-1:0]   out_dat_q;
    logic                  rdy_out;

    assign rdy_out = ~out_vld_q | out_ready;

    if (PIPE >= 2) begin : g_raw
      logic                raw_vld_q;
      logic [32*LANES-1:0] raw_dat_q;
      logic [LANES-1:0]    raw_sel_q;
      logic                rdy_raw;

      assign rdy_raw  = ~raw_vld_q | rdy_out;
      assign in_ready = rdy_raw;
      assign mix_vld  = raw_vld_q;
      assign mix_src  = raw_dat_q;
      assign mix_sel  = raw_sel_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          raw_vld_q <= 1'b0;
          raw_dat_q <= '0;
          raw_sel_q <= '0;
        end else if (rdy_raw) begin
          raw_vld_q <= in_valid;
          raw_dat_q <= in_data;
          raw_sel_q <= in_sel;
        end
      end
    end else begin : g_direct
      assign in_ready = rdy_out;
      assign mix_vld  = in_valid;
      assign mix_src  = in_data;
      assign mix_sel  = in_sel;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
      clefia_m0m1_core u_core (
        .word_i (mix_src[32*i +: 32]),
        .sel_i  (mix_sel[i]),
        .word_o (mix_res[32*i +: 32])
      );
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_vld_q <= 1'b0;
        out_dat_q <= '0;
      end else if (rdy_out) begin
        out_vld_q <= mix_vld;
        out_dat_q <= mix_res;
      end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign dbg_state = ST_IDLE;
  end

endmodule

// File: tb/tb_clefia_diffusion_pipe.sv
// Bench for clefia_diffusion_pipe across six parameter sets run side by
// side: (LANES,SERIAL,PIPE) = (1,0,1) (1,1,-) (4,0,1) (4,0,2) (4,1,-) (1,0,2).
module tb_clefia_diffusion_pipe;

  localparam int NCFG = 6;

  function automatic int cfg_lanes(input int g);
    return (g == 2 || g == 3 || g == 4) ? 4 : 1;
  endfunction
  function automatic int cfg_serial(input int g);
    return (g == 1 || g == 4) ? 1 : 0;
  endfunction
  function automatic int cfg_pipe(input int g);
    return (g == 3 || g == 5) ? 2 : 1;
  endfunction

  // ---------------- clock / reset-independent globals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int bad    = 0;
  int n_done = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  localparam logic [7:0] M0_T [16] = '{8'h1, 8'h2, 8'h4, 8'h6,
                                       8'h2, 8'h1, 8'h6, 8'h4,
                                       8'h4, 8'h6, 8'h1, 8'h2,
                                       8'h6, 8'h4, 8'h2, 8'h1};
  localparam logic [7:0] M1_T [16] = '{8'h1, 8'h8, 8'h2, 8'hA,
                                       8'h8, 8'h1, 8'hA, 8'h2,
                                       8'h2, 8'hA, 8'h1, 8'h8,
                                       8'hA, 8'h2, 8'h8, 8'h1};

  // Schoolbook carry-less product, then long division by 0x11D.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] w, input logic s);
    logic [31:0] y;
    logic [7:0]  acc;
    logic [7:0]  co;
    y = '0;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int c = 0; c < 4; c++) begin
        co  = s ? M1_T[4*r + c] : M0_T[4*r + c];
        acc = acc ^ gmul(co, w[31 - 8*c -: 8]);
      end
      y[31 - 8*r -: 8] = acc;
    end
    return y;
  endfunction

  function automatic logic [255:0] model_vec(input logic [255:0] d,
                                             input logic [7:0] s, input int lanes);
    logic [255:0] y;
    y = '0;
    for (int i = 0; i < lanes; i++) y[32*i +: 32] = model_word(d[32*i +: 32], s[i]);
    return y;
  endfunction

  // Hand-computed values pin the model before any DUT is trusted to it.
  initial begin
    chk(model_word(32'h01000000, 1'b0) == 32'h01020406, "model M0 X0=01",
        128'(model_word(32'h01000000, 1'b0)), 128'h01020406);
    chk(model_word(32'h01000000, 1'b1) == 32'h0108020A, "model M1 X0=01",
        128'(model_word(32'h01000000, 1'b1)), 128'h0108020A);
    chk(model_word(32'h80000000, 1'b0) == 32'h801D3A27, "model M0 X0=80",
        128'(model_word(32'h80000000, 1'b0)), 128'h801D3A27);
    chk(model_word(32'h00010000, 1'b0) == 32'h02010604, "model M0 X1=01",
        128'(model_word(32'h00010000, 1'b0)), 128'h02010604);
  end

  // ---------------- one DUT + driver + scoreboard per config ----------------
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int G   = g;
    localparam int L   = cfg_lanes(g);
    localparam int S   = cfg_serial(g);
    localparam int P   = cfg_pipe(g);
    localparam int LAT = (S != 0) ? L + 1 : P;
    localparam int NSTREAM = 300;
    localparam int NINV    = 1000;

    logic              rst_n;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [32*L-1:0]   in_data, out_data;
    logic [L-1:0]      in_sel;
    logic [1:0]        dbg;

    clefia_diffusion_pipe #(.LANES(L), .SERIAL(S), .PIPE(P)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .dbg_state (dbg)
    );

    function automatic logic [32*L-1:0] rnd_data();
      logic [32*L-1:0] r;
      for (int i = 0; i < L; i++) r[32*i +: 32] = $urandom;
      return r;
    endfunction

    function automatic string nm(input string s);
      return $sformatf("c%0d %s", G, s);
    endfunction

    // ---- scoreboard: expected queue fed on accept, drained on delivery ----
    logic [32*L-1:0] exp_q[$];
    logic [32*L-1:0] prev_data;
    bit              stall_pend = 1'b0;

    always @(negedge clk) begin
      logic [255:0]    m;
      logic [32*L-1:0] e;
      if (!rst_n) begin
        exp_q.delete();
        stall_pend = 1'b0;
      end else begin
        if (stall_pend)
          chk(out_valid && out_data == prev_data, nm("stall hold"),
              128'(out_data), 128'(prev_data));
        stall_pend = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, nm("unexpected output"), 128'(out_data), 128'h0);
          end else begin
            e = exp_q.pop_front();
            chk(out_data == e, nm("data"), 128'(out_data), 128'(e));
          end
        end
        if (in_valid && in_ready) begin
          m = model_vec(256'(in_data), 8'(in_sel), L);
          exp_q.push_back(m[32*L-1:0]);
        end
        if (S != 0 && dbg == 2'd1)
          chk(in_ready == 1'b0, nm("in_ready in RUN"), 128'(in_ready), 128'h0);
      end
    end

    // ---- driver tasks ----
    task automatic send_one(input logic [32*L-1:0] d, input logic [L-1:0] s,
                            output logic [32*L-1:0] y, output int lat);
      int k;
      in_data   = d;
      in_sel    = s;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) chk(1'b0, nm("accept timeout"), 128'(k), 128'h0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = rnd_data();
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      y = out_data;
      if (!out_valid) chk(1'b0, nm("output timeout"), 128'(lat), 128'(LAT));
      @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk(out_valid == 1'b0, nm("reset out_valid"), 128'(out_valid), 128'h0);
      chk(out_data == '0, nm("reset out_data"), 128'(out_data), 128'h0);
      chk(dbg == 2'd0, nm("reset state"), 128'(dbg), 128'h0);
      chk(in_ready == 1'b1, nm("reset in_ready"), 128'(in_ready), 128'h1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int c = 0; c < L + 4; c++) begin
        @(negedge clk);
        chk(out_valid == 1'b0, nm("no stale result"), 128'(out_valid), 128'h0);
        @(posedge clk); #1;
      end
    endtask

    task automatic accept_and_hold(input logic [32*L-1:0] d);
      int k;
      in_data   = d;
      in_sel    = '1;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    endtask

    // ---- main sequence ----
    initial begin
      logic [32*L-1:0] x, y, z;
      logic [L-1:0]    s;
      logic [31:0]     lit_in  [4];
      logic [31:0]     lit_out [4];
      logic            lit_sel [4];
      int lat, lat2, k;

      lit_in[0] = 32'h01000000; lit_sel[0] = 1'b0; lit_out[0] = 32'h01020406;
      lit_in[1] = 32'h01000000; lit_sel[1] = 1'b1; lit_out[1] = 32'h0108020A;
      lit_in[2] = 32'h80000000; lit_sel[2] = 1'b0; lit_out[2] = 32'h801D3A27;
      lit_in[3] = 32'h00010000; lit_sel[3] = 1'b0; lit_out[3] = 32'h02010604;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk(out_valid == 1'b0, nm("init out_valid"), 128'(out_valid), 128'h0);
      chk(out_data == '0, nm("init out_data"), 128'(out_data), 128'h0);
      chk(in_ready == 1'b1, nm("init in_ready"), 128'(in_ready), 128'h1);
      chk(dbg == 2'd0, nm("init state"), 128'(dbg), 128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Literal vectors broadcast on every lane.
      for (int t = 0; t < 4; t++) begin
        send_one({L{lit_in[t]}}, {L{lit_sel[t]}}, y, lat);
        chk(y == {L{lit_out[t]}}, nm("literal"), 128'(y), 128'({L{lit_out[t]}}));
        chk(lat == LAT, nm("latency"), 128'(lat), 128'(LAT));
      end

      // Involution round trips.
      for (int t = 0; t < NINV; t++) begin
        x = rnd_data();
        s = L'($urandom);
        send_one(x, s, y, lat);
        send_one(y, s, z, lat2);
        chk(z == x, nm("involution"), 128'(z), 128'(x));
        chk(lat == LAT && lat2 == LAT, nm("latency rt"), 128'(lat), 128'(LAT));
      end

      // Random valid / random ready streaming, mixed select.
      fork
        begin : producer
          int sent = 0;
          int cyc  = 0;
          while (sent < NSTREAM && cyc < 20000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = rnd_data();
            in_sel   = (L == 4) ? L'(4'b1010) : L'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
          end
          in_valid = 1'b0;
          if (sent < NSTREAM) chk(1'b0, nm("producer timeout"), 128'(sent), 128'(NSTREAM));
        end
        begin : consumer
          int got = 0;
          int cyc = 0;
          while (got < NSTREAM && cyc < 20000) begin
            out_ready = $urandom_range(0, 1);
            @(negedge clk);
            if (out_valid && out_ready) got++;
            @(posedge clk); #1;
            cyc++;
          end
          if (got < NSTREAM) chk(1'b0, nm("consumer timeout"), 128'(got), 128'(NSTREAM));
        end
      join
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Throughput with out_ready held high.
      if (S == 0) begin
        for (int c = 0; c < 20 + P; c++) begin
          in_valid = (c < 20);
          in_data  = rnd_data();
          in_sel   = L'($urandom);
          @(negedge clk);
          if (c < 20) chk(in_ready == 1'b1, nm("tput in_ready"), 128'(in_ready), 128'h1);
          if (c >= P) chk(out_valid == 1'b1, nm("tput out_valid"), 128'(out_valid), 128'h1);
          @(posedge clk); #1;
        end
      end else begin
        for (int c = 0; c <= 3 * LAT; c++) begin
          in_valid = (c < 3 * LAT);
          if (in_ready || c == 0) in_data = rnd_data();
          in_sel   = L'($urandom);
          @(negedge clk);
          if (c < 3 * LAT)
            chk(in_ready == ((c % LAT) == 0), nm("b2b in_ready"),
                128'(in_ready), 128'((c % LAT) == 0));
          chk(out_valid == ((c % LAT) == 0 && c > 0), nm("b2b out_valid"),
              128'(out_valid), 128'((c % LAT) == 0 && c > 0));
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset one cycle after accept (serial: mid RUN).
      accept_and_hold(rnd_data());
      @(negedge clk);
      if (S != 0) chk(dbg == 2'd1, nm("in RUN"), 128'(dbg), 128'h1);
      @(posedge clk); #1;
      reset_pulse();

      // Reset while the result is stalled at the output.
      accept_and_hold(rnd_data());
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk(out_valid == 1'b1, nm("stalled before reset"), 128'(out_valid), 128'h1);
      @(posedge clk); #1;
      reset_pulse();

      chk(exp_q.size() == 0, nm("drained"), 128'(exp_q.size()), 128'h0);
      n_done++;
    end
  end

  // ---------------- final report ----------------
  initial begin
    for (int t = 0; t < 90000 && n_done < NCFG; t++) @(posedge clk);
    if (n_done < NCFG) chk(1'b0, "global timeout", 128'(n_done), 128'(NCFG));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
